// File: rtl/prbs23_checker_pkg.sv
// Shared PRBS-23 definitions: polynomial taps, checker state encoding and the predictor.
package prbs23_checker_pkg;

  localparam int PRBS_LEN = 23;
  localparam int TAP_A    = 4;
  localparam int TAP_B    = 22;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic prbs_pred(input logic [PRBS_LEN-1:0] sr);
    return sr[TAP_A] ^ sr[TAP_B];
  endfunction

endpackage

// File: rtl/prbs23_checker_win_mon.sv
// Error-density monitor: counts errors per WINDOW-bit window and flags loss of lock.
module prbs_win_mon
  import prbs23_checker_pkg::*;
#(
  parameter int WINDOW     = 256,
  parameter int UNLOCK_ERR = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic beat_i,
  input  logic err_i,
  output logic unlock_o
);

  localparam int BW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(UNLOCK_ERR + 1);
  localparam logic [BW-1:0] WRAP_AT = BW'(WINDOW - 1);
  localparam logic [EW:0]   ERR_LIM = (EW+1)'(UNLOCK_ERR);

  logic [BW-1:0] bit_q, bit_d;
  logic [EW-1:0] err_q, err_d;
  logic [EW:0]   err_sum;
  logic          wrap;

  // The current error is added before the unlock test; a wrap on the same beat then zeroes the count.
  always_comb begin
    err_sum  = {1'b0, err_q} + {{EW{1'b0}}, err_i};
    wrap     = (bit_q == WRAP_AT);
    unlock_o = beat_i && (err_sum >= ERR_LIM);
    bit_d    = bit_q;
    err_d    = err_q;
    if (clr_i) begin
      bit_d = '0;
      err_d = '0;
    end else if (beat_i) begin
      bit_d = wrap ? '0 : bit_q + BW'(1);
      err_d = wrap ? '0 : err_sum[EW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= '0;
      err_q <= '0;
    end else begin
      bit_q <= bit_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/prbs23_checker.sv
// Self-synchronising PRBS-23 checker: seeds from the stream, acquires lock, then counts bit errors
// against a free-running local reference.
module prbs23_checker
  import prbs23_checker_pkg::*;
#(
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_ERR = 8,
  parameter int WINDOW     = 256,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             lock_lost
);

  localparam int FW = $clog2(PRBS_LEN);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [FW-1:0] FILL_LAST  = FW'(PRBS_LEN - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);

  state_e               state_q, state_d;
  logic [PRBS_LEN-1:0]  sr_q, sr_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [MW-1:0]        match_q, match_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d, bit_cnt_q, bit_cnt_d;
  logic                 lock_lost_q, lock_lost_d, err_pulse_q, err_pulse_d;
  logic                 pred, mismatch, win_beat, win_unlock;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign pred     = prbs_pred(sr_q);
  assign mismatch = din ^ pred;
  assign win_beat = din_valid && (state_q == LOCKED);

  prbs_win_mon #(
    .WINDOW     (WINDOW),
    .UNLOCK_ERR (UNLOCK_ERR)
  ) u_win_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != LOCKED),
    .beat_i   (win_beat),
    .err_i    (mismatch),
    .unlock_o (win_unlock)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    lock_lost_d = lock_lost_q;
    err_pulse_d = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        SEED: begin
          sr_d = {sr_q[PRBS_LEN-2:0], din};
          if (fill_q == FILL_LAST) begin
            fill_d  = '0;
            match_d = '0;
            if (sr_d != '0) state_d = ACQ;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
        ACQ: begin
          if (!mismatch) begin
            sr_d    = {sr_q[PRBS_LEN-2:0], pred};
            match_d = match_q + MW'(1);
            if (match_q == MATCH_LAST) state_d = LOCKED;
          end else begin
            fill_d  = '0;
            state_d = SEED;
          end
        end
        LOCKED: begin
          sr_d      = {sr_q[PRBS_LEN-2:0], pred};
          bit_cnt_d = sat_inc(bit_cnt_q);
          if (mismatch) begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc(err_cnt_q);
          end
          if (win_unlock) begin
            state_d     = SEED;
            fill_d      = '0;
            lock_lost_d = 1'b1;
          end
        end
        default: begin
          state_d = SEED;
          fill_d  = '0;
        end
      endcase
    end
    // Clear overrides any count or lock_lost update made on the same cycle.
    if (clear) begin
      err_cnt_d   = '0;
      bit_cnt_d   = '0;
      lock_lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      lock_lost_q <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      lock_lost_q <= lock_lost_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign bit_cnt   = bit_cnt_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_prbs23_checker.sv
// Directed bench for prbs23_checker: lock acquisition, error counting, windowed unlock, clear and reset.
module tb_prbs23_checker;

  localparam int CNT_W = 32;
  localparam logic [22:0] GEN_SEED = 23'd4790770;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             clear = 1'b0;
  logic             locked, err_pulse, lock_lost;
  logic [CNT_W-1:0] err_cnt, bit_cnt;

  int checks = 0;
  int failures = 0;
  logic [22:0] g;

  prbs23_checker #(
    .LOCK_CNT(64), .UNLOCK_ERR(8), .WINDOW(256), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt),
    .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  function automatic logic gen_next();
    logic y;
    y = g[4] ^ g[22];
    g = {g[21:0], y};
    return y;
  endfunction

  task automatic send_bit(input logic flip);
    din = gen_next() ^ flip;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic b);
    din = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    din_valid = 1'b0;
    din = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    clear = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    g = GEN_SEED;
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({locked, err_pulse, lock_lost} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {locked, err_pulse, lock_lost});
    end
    checks++;
    if (err_cnt !== '0 || bit_cnt !== '0) begin
      failures++; $display("FAIL reset_cnts err_cnt=%0d bit_cnt=%0d exp=0/0", err_cnt, bit_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    int pulses;
    do_reset();
    send_good(86);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL lock_early locked=%b exp=0", locked); end
    send_good(1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL lock_at_87 locked=%b exp=1", locked); end
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      send_bit(1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL clean_pulses got=%0d exp=0", pulses); end
    checks++;
    if (err_cnt !== 32'd0 || bit_cnt !== 32'd1000) begin
      failures++; $display("FAIL clean_cnts err_cnt=%0d bit_cnt=%0d exp=0/1000", err_cnt, bit_cnt);
    end
  endtask

  task automatic test_single_flip();
    send_bit(1'b1);
    checks++;
    if (err_pulse !== 1'b1) begin failures++; $display("FAIL flip_pulse got=%b exp=1", err_pulse); end
    send_bit(1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin failures++; $display("FAIL flip_pulse_width got=%b exp=0", err_pulse); end
    send_good(50);
    checks++;
    if (err_cnt !== 32'd1 || locked !== 1'b1) begin
      failures++; $display("FAIL flip_cnt err_cnt=%0d locked=%b exp=1/1", err_cnt, locked);
    end
  endtask

  task automatic test_unlock();
    do_reset();
    send_good(87);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL unlock_7 locked=%b exp=1", locked); end
    send_bit(1'b1);
    checks++;
    if (locked !== 1'b0 || lock_lost !== 1'b1) begin
      failures++; $display("FAIL unlock_8 locked=%b lock_lost=%b exp=0/1", locked, lock_lost);
    end
    send_good(86);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL relock_early locked=%b exp=0", locked); end
    send_good(1);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 32'd8 || lock_lost !== 1'b1) begin
      failures++;
      $display("FAIL relock locked=%b err_cnt=%0d lock_lost=%b exp=1/8/1", locked, err_cnt, lock_lost);
    end
  endtask

  task automatic test_clear();
    clear = 1'b1;
    send_bit(1'b1);
    clear = 1'b0;
    checks++;
    if (err_pulse !== 1'b1) begin failures++; $display("FAIL clear_pulse got=%b exp=1", err_pulse); end
    checks++;
    if (err_cnt !== 32'd0 || bit_cnt !== 32'd0 || lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL clear_cnts err_cnt=%0d bit_cnt=%0d lock_lost=%b exp=0/0/0", err_cnt, bit_cnt, lock_lost);
    end
    send_bit(1'b0);
    checks++;
    if (bit_cnt !== 32'd1 || locked !== 1'b1) begin
      failures++; $display("FAIL clear_after bit_cnt=%0d locked=%b exp=1/1", bit_cnt, locked);
    end
  endtask

  task automatic test_window();
    logic flip;
    do_reset();
    send_good(87);
    for (int w = 0; w < 4; w++) begin
      for (int p = 0; p < 256; p++) begin
        flip = (w == 0) ? (p >= 249) : (p < 7);
        send_bit(flip);
      end
      checks++;
      if (locked !== 1'b1) begin failures++; $display("FAIL window_%0d locked=%b exp=1", w, locked); end
    end
    checks++;
    if (err_cnt !== 32'd28 || bit_cnt !== 32'd1024 || lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL window_cnts err_cnt=%0d bit_cnt=%0d lock_lost=%b exp=28/1024/0", err_cnt, bit_cnt, lock_lost);
    end
  endtask

  task automatic test_zero();
    int seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 506; i++) begin
      send_raw(1'b0);
      if (locked !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL zero_locked cycles=%0d exp=0", seen); end
    send_good(86);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL zero_relock_early locked=%b exp=0", locked); end
    send_good(1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL zero_relock locked=%b exp=1", locked); end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 0; i < 86; i++) begin
      send_bit(1'b0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) idle_cycle();
    end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL gaps_early locked=%b exp=0", locked); end
    send_bit(1'b0);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL gaps_lock locked=%b exp=1", locked); end
    for (int i = 0; i < 1000; i++) begin
      send_bit(1'b0);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    checks++;
    if (err_cnt !== 32'd0 || bit_cnt !== 32'd1000) begin
      failures++; $display("FAIL gaps_cnts err_cnt=%0d bit_cnt=%0d exp=0/1000", err_cnt, bit_cnt);
    end
  endtask

  task automatic test_reset_mid();
    send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({locked, err_pulse, lock_lost} !== 3'b000 || err_cnt !== '0 || bit_cnt !== '0) begin
      failures++;
      $display("FAIL mid_reset flags=%b err_cnt=%0d bit_cnt=%0d exp=000/0/0",
               {locked, err_pulse, lock_lost}, err_cnt, bit_cnt);
    end
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    g = GEN_SEED;
    send_good(86);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL mid_relock_early locked=%b exp=0", locked); end
    send_good(1);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL mid_relock locked=%b exp=1", locked); end
  endtask

  initial begin
    g = GEN_SEED;
    test_reset();
    test_lock();
    test_single_flip();
    test_unlock();
    test_clear();
    test_window();
    test_zero();
    test_gaps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
